adder_seq_chunked: RTL and testbench



---
 rtl/adder_seq_chunked.sv | 133 +++++++++++++
 tb/tb_adder_seq_chunked.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_chunked.sv
// Multi-cycle wide adder/subtractor: one CHUNK-bit slice per cycle, with the inter-slice
// carry held in a register. Valid/ready on both sides; the result is held in DONE until taken.
//
// state | meaning
// IDLE  | ready for operands; in_ready=1
// RUN   | adding slice idx, carry registered between slices
// DONE  | out/cout/ovf valid and held until out_ready
module adder_seq_chunked #(
  parameter int unsigned ADDER_SIZE = 1024,
  parameter int unsigned CHUNK      = 128
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDER_SIZE-1:0] A,
  input  logic [ADDER_SIZE-1:0] B,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDER_SIZE-1:0] out,
  output logic                  cout,
  output logic                  ovf
);

  localparam int unsigned NCHUNK = ADDER_SIZE / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (ADDER_SIZE % CHUNK != 0) begin : g_bad_chunk
    $error("adder_seq_chunked: ADDER_SIZE must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDER_SIZE-1:0]   a_q, a_d;
  logic [ADDER_SIZE-1:0]   b_q, b_d;
  logic                    carry_q, carry_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ADDER_SIZE-1:0]   out_q, out_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;

  logic [31:0]             base;
  logic [CHUNK-1:0]        slice_a;
  logic [CHUNK-1:0]        slice_b;
  logic [CHUNK:0]          sum;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    base    = 32'(idx_q) * CHUNK;
    slice_a = a_q[base +: CHUNK];
    slice_b = b_q[base +: CHUNK];
    sum     = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // subtract is A + ~B + 1, so the borrow-in rides on the initial carry
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        out_d[base +: CHUNK] = sum[CHUNK-1:0];
        carry_d              = sum[CHUNK];
        if (idx_q == LAST_IDX) begin
          cout_d  = sum[CHUNK];
          ovf_d   = (slice_a[CHUNK-1] == slice_b[CHUNK-1]) &&
                    (sum[CHUNK-1] != slice_a[CHUNK-1]);
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_seq_chunked.sv
// Bench for adder_seq_chunked: directed cases on the 1024/128 build, plus random
// sweeps on 1024/1024 and 384/64 builds checked against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_adder_seq_chunked;

  localparam int W    = 1024;
  localparam int D_NC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h, %0d bits differ", tag,
               obs[W-1:W-64], obs[63:0], exp[W-1:W-64], exp[63:0], $countones(obs ^ exp));
    end
  endtask

  // {ovf, cout, out} from ordinary modular arithmetic and sign rules
  function automatic logic [W+1:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci, input logic s);
    logic [W:0]   tot;
    logic [W-1:0] r;
    logic         c, v;
    tot = '0;
    if (s) begin
      r = a - b;
      c = (a >= b);
      v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      tot = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      r   = tot[W-1:0];
      c   = tot[W];
      v   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {v, c, r};
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      2: v = {1'b0, {(W-1){1'b1}}};
      default: ;
    endcase
    return v;
  endfunction

  // default build, directed tests
  logic         d_rstn, d_iv, d_ir, d_cin, d_sub, d_ov, d_or, d_cout, d_ovf;
  logic [W-1:0] d_a, d_b, d_out;

  adder_seq_chunked #(.ADDER_SIZE(1024), .CHUNK(128)) u_dut (
    .clk(clk), .resetn(d_rstn), .in_valid(d_iv), .in_ready(d_ir),
    .A(d_a), .B(d_b), .cin(d_cin), .sub(d_sub),
    .out_valid(d_ov), .out_ready(d_or), .out(d_out), .cout(d_cout), .ovf(d_ovf)
  );

  // all directed tasks are entered and left 1 time unit after a rising edge
  task automatic d_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic s);
    int t;
    d_a = a; d_b = b; d_cin = ci; d_sub = s; d_iv = 1'b1;
    t = 0;
    while (!d_ir && t < 20) begin @(posedge clk); #1; t++; end
    chk("accept.rdy", W'(d_ir), W'(1));
    @(posedge clk); #1 d_iv = 1'b0;
  endtask

  task automatic d_wait_done(output int lat);
    lat = 0;
    while (!d_ov && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic d_check(input string tag, input int lat, input logic [W-1:0] eo,
                         input logic ec, input logic ev);
    chk({tag, ".lat"},  W'(lat), W'(D_NC));
    chk({tag, ".out"},  d_out, eo);
    chk({tag, ".cout"}, W'(d_cout), W'(ec));
    chk({tag, ".ovf"},  W'(d_ovf), W'(ev));
    chk({tag, ".ir"},   W'(d_ir), W'(0));
  endtask

  task automatic d_release(input string tag);
    d_or = 1'b1;
    @(posedge clk); #1 d_or = 1'b0;
    chk({tag, ".rel"}, W'({d_ov, d_ir}), W'(2'b01));
  endtask

  task automatic d_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic s, input logic [W-1:0] eo,
                      input logic ec, input logic ev);
    int lat;
    d_accept(a, b, ci, s);
    d_wait_done(lat);
    d_check(tag, lat, eo, ec, ev);
    d_release(tag);
  endtask

  task automatic d_chk_reset(input string tag);
    chk({tag, ".ir"},   W'(d_ir), W'(1));
    chk({tag, ".ov"},   W'(d_ov), W'(0));
    chk({tag, ".out"},  d_out, '0);
    chk({tag, ".cout"}, W'(d_cout), W'(0));
    chk({tag, ".ovf"},  W'(d_ovf), W'(0));
  endtask

  // random sweeps on the other two builds
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int AS = (g == 0) ? 1024 : 384;
    localparam int CH = (g == 0) ? 1024 : 64;
    localparam int NC = AS / CH;

    logic          rstn, iv, ir, ci, sb, ov, ordy, co, of;
    logic [AS-1:0] a, b, o;
    bit            done_flag = 1'b0;

    adder_seq_chunked #(.ADDER_SIZE(AS), .CHUNK(CH)) u_dut (
      .clk(clk), .resetn(rstn), .in_valid(iv), .in_ready(ir),
      .A(a), .B(b), .cin(ci), .sub(sb),
      .out_valid(ov), .out_ready(ordy), .out(o), .cout(co), .ovf(of)
    );

    function automatic logic [AS+1:0] model(input logic [AS-1:0] x, input logic [AS-1:0] y,
                                            input logic c_in, input logic s);
      logic [AS:0]   tot;
      logic [AS-1:0] r;
      logic          c, v;
      tot = '0;
      if (s) begin
        r = x - y;
        c = (x >= y);
        v = (x[AS-1] != y[AS-1]) && (r[AS-1] != x[AS-1]);
      end else begin
        tot = {1'b0, x} + {1'b0, y} + {{AS{1'b0}}, c_in};
        r   = tot[AS-1:0];
        c   = tot[AS];
        v   = (x[AS-1] == y[AS-1]) && (r[AS-1] != x[AS-1]);
      end
      return {v, c, r};
    endfunction

    initial begin : p_sweep
      logic [AS+1:0] e;
      int            lat, t;
      string         pfx;
      pfx  = $sformatf("sw%0d", g);
      rstn = 1'b0; iv = 1'b0; ordy = 1'b0; a = '0; b = '0; ci = 1'b0; sb = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      for (int n = 0; n < 1000; n++) begin
        a  = AS'(rnd_w());
        b  = AS'(rnd_w());
        ci = 1'($urandom);
        sb = 1'($urandom);
        e  = model(a, b, ci, sb);
        iv = 1'b1;
        t  = 0;
        while (!ir && t < 10) begin @(posedge clk); #1; t++; end
        chk({pfx, ".rdy"}, W'(ir), W'(1));
        @(posedge clk); #1 iv = 1'b0;
        lat = 0;
        while (!ov && lat < NC + 10) begin
          ordy = 1'($urandom);
          @(posedge clk); #1;
          lat++;
        end
        chk({pfx, ".lat"},  W'(lat), W'(NC));
        chk({pfx, ".out"},  W'(o), W'(e[AS-1:0]));
        chk({pfx, ".cout"}, W'(co), W'(e[AS]));
        chk({pfx, ".ovf"},  W'(of), W'(e[AS+1]));
        t = 0;
        while (t < 8 && $urandom_range(0, 2) != 0) begin
          ordy = 1'b0;
          @(posedge clk); #1;
          t++;
          chk({pfx, ".hold"}, W'({ov, ir, co, of}), W'({1'b1, 1'b0, e[AS], e[AS+1]}));
          chk({pfx, ".hout"}, W'(o), W'(e[AS-1:0]));
        end
        ordy = 1'b1;
        @(posedge clk); #1 ordy = 1'b0;
        chk({pfx, ".rel"}, W'({ov, ir}), W'(2'b01));
      end
      done_flag = 1'b1;
    end
  end

  initial begin : p_watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin : p_main
    logic [W-1:0] ones, mpos, mneg, ra, rb, a2, b2;
    logic [W+1:0] e, e2;
    logic         rc, rs;
    int           lat;

    ones = '1;
    mpos = ones >> 1;
    mneg = ~mpos;
    d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
    d_iv = 1'b0; d_or = 1'b0; d_rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 d_rstn = 1'b1;
    d_chk_reset("rst");

    d_op("ones",    ones,  '0,    1'b1, 1'b0, '0,            1'b1, 1'b0);
    d_op("sub5_7",  W'(5), W'(7), 1'b0, 1'b1, ones ^ W'(1),  1'b0, 1'b0);
    d_op("sub5_7c", W'(5), W'(7), 1'b1, 1'b1, ones ^ W'(1),  1'b0, 1'b0);
    d_op("posovf",  mpos,  W'(1), 1'b0, 1'b0, mneg,          1'b0, 1'b1);
    d_op("negovf",  mneg,  W'(1), 1'b0, 1'b1, mpos,          1'b1, 1'b1);

    // backpressure: held result, blocked second bundle, then prompt acceptance
    ra = rnd_w(); rb = rnd_w(); e  = model_add(ra, rb, 1'b0, 1'b0);
    a2 = rnd_w(); b2 = rnd_w(); e2 = model_add(a2, b2, 1'b1, 1'b1);
    d_accept(ra, rb, 1'b0, 1'b0);
    d_wait_done(lat);
    d_check("bp1", lat, e[W-1:0], e[W], e[W+1]);
    d_a = a2; d_b = b2; d_cin = 1'b1; d_sub = 1'b1; d_iv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.hout", d_out, e[W-1:0]);
      chk("bp.hflags", W'({d_ov, d_ir, d_cout, d_ovf}), W'({1'b1, 1'b0, e[W], e[W+1]}));
    end
    d_or = 1'b1;
    @(posedge clk); #1 d_or = 1'b0;
    chk("bp.idle", W'({d_ov, d_ir}), W'(2'b01));
    @(posedge clk); #1;
    chk("bp.acc", W'(d_ir), W'(0));
    d_iv = 1'b0;
    d_wait_done(lat);
    d_check("bp2", lat, e2[W-1:0], e2[W], e2[W+1]);
    d_release("bp2");

    // reset at RUN idx=3 discards the operation
    d_accept(rnd_w(), rnd_w(), 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 d_rstn = 1'b0;
    @(posedge clk); #1 d_rstn = 1'b1;
    d_chk_reset("midrst");
    ra = rnd_w(); rb = rnd_w(); e = model_add(ra, rb, 1'b0, 1'b1);
    d_op("postrst", ra, rb, 1'b0, 1'b1, e[W-1:0], e[W], e[W+1]);

    for (int n = 0; n < 30; n++) begin
      ra = rnd_w(); rb = rnd_w(); rc = 1'($urandom); rs = 1'($urandom);
      e  = model_add(ra, rb, rc, rs);
      d_op("rnd", ra, rb, rc, rs, e[W-1:0], e[W], e[W+1]);
    end

    for (int t = 0; t < 60000 && !(g_sweep[0].done_flag && g_sweep[1].done_flag); t++)
      @(posedge clk);
    chk("sweep.done", W'({g_sweep[0].done_flag, g_sweep[1].done_flag}), W'(2'b11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
